wb_serial_master: RTL and testbench

- Byte-stream-to-Wishbone initiator: a debug/boot bus master driven by the UART receive byte stream.
- Decodes single-word read/write commands and runs one classic Wishbone cycle per command on a spare conbus master port.
- Returns the result as bytes to the UART transmit side.
- Gives a host PC direct access to bram, timer, pwm and cam registers without CPU firmware.

---
 rtl/wb_serial_master.sv | 177 +++++++++++++++++
 tb/tb_wb_serial_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_serial_master.sv
// Byte-stream-to-Wishbone initiator: decodes 'W'/'R' frames from the UART byte stream,
// runs one classic Wishbone cycle per frame and streams the response bytes back.
module wb_serial_master #(
  parameter int unsigned BUS_TIMEOUT = 1024,
  parameter logic [7:0]  CMD_WR      = 8'h57,
  parameter logic [7:0]  CMD_RD      = 8'h52,
  parameter logic [7:0]  RSP_OK      = 8'h06,
  parameter logic [7:0]  RSP_ERR     = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overrun,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  localparam int unsigned TMO_W = 16;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(BUS_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_write;
  logic [1:0]       r_cnt;
  logic [31:0]      r_adr;
  logic [31:0]      r_wdat;
  logic [31:0]      r_shift;
  logic [TMO_W-1:0] r_tmo;
  logic [1:0]       r_left;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_overrun;
  logic             r_cyc;
  logic             r_we;
  logic [3:0]       r_sel;

  logic             w_last_byte;
  logic             w_bus_start;
  logic [TMO_W-1:0] w_tmo_next;

  // Fourth byte of the address (read) or data (write) field launches the bus cycle.
  assign w_last_byte = rx_valid && (r_cnt == 2'd3);
  assign w_bus_start = w_last_byte &&
                       (((r_state == S_ADDR) && !r_write) || (r_state == S_DATA));
  assign w_tmo_next  = r_tmo + TMO_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_cnt      <= '0;
      r_adr      <= '0;
      r_wdat     <= '0;
      r_shift    <= '0;
      r_tmo      <= '0;
      r_left     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= '0;
    end else begin
      if (rx_valid && ((r_state == S_BUS) || (r_state == S_RESP))) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (rx_valid && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
            r_write <= (rx_data == CMD_WR);
            r_cnt   <= '0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_adr <= {r_adr[23:0], rx_data};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= r_write ? S_DATA : S_BUS;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_wdat <= {r_wdat[23:0], rx_data};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // An ack on the final timeout cycle still wins over the timeout.
          if (wb_ack_i) begin
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_tx_valid <= 1'b1;
            r_state    <= S_RESP;
            if (r_we) begin
              r_tx_data <= RSP_OK;
              r_left    <= 2'd0;
            end else begin
              r_tx_data <= wb_dat_i[31:24];
              r_shift   <= {wb_dat_i[23:0], 8'h00};
              r_left    <= 2'd3;
            end
          end else if (w_tmo_next == TMO_LIMIT) begin
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= RSP_ERR;
            r_left     <= 2'd0;
            r_state    <= S_RESP;
          end else begin
            r_tmo <= w_tmo_next;
          end
        end
        S_RESP: begin
          // Valid drops for one cycle after each handshake before the next byte.
          if (r_tx_valid) begin
            if (tx_ready) begin
              r_tx_valid <= 1'b0;
              if (r_left == 2'd0) begin
                r_state <= S_IDLE;
              end
            end
          end else begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_shift[31:24];
            r_shift    <= {r_shift[23:0], 8'h00};
            r_left     <= r_left - 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_bus_start) begin
        r_cyc <= 1'b1;
        r_sel <= 4'hF;
        r_we  <= r_write;
        r_tmo <= '0;
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign overrun  = r_overrun;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_wdat;
  assign wb_sel_o = r_sel;
  assign wb_we_o  = r_we;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;

endmodule

// File: tb/tb_wb_serial_master.sv
// Randomized bench for wb_serial_master: Wishbone slave model, UART tx sink and a
// frame-level reference model predicting each bus transaction and response stream.
module tb_wb_serial_master;

  localparam int unsigned TMO     = 16;
  localparam logic [7:0]  CMD_WR  = 8'h57;
  localparam logic [7:0]  CMD_RD  = 8'h52;
  localparam logic [7:0]  RSP_OK  = 8'h06;
  localparam logic [7:0]  RSP_ERR = 8'h15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overrun;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  always #5 clk = ~clk;

  wb_serial_master #(.BUS_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .overrun(overrun),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Wishbone slave: acks after cur_delay wait cycles, records each cycle it observes.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          ncyc;
    int          start;
    bit          stable;
  } bus_rec_t;

  bus_rec_t    mon_q[$];
  bus_rec_t    cur;
  int          cur_delay = 0;
  logic [31:0] cur_rdata = '0;
  bit          in_cyc    = 1'b0;

  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o === 1'b1) begin
        if (!in_cyc) begin
          in_cyc     = 1'b1;
          cur.adr    = wb_adr_o;
          cur.dat    = wb_dat_o;
          cur.we     = wb_we_o;
          cur.sel    = wb_sel_o;
          cur.ncyc   = 0;
          cur.start  = cyc_n;
          cur.stable = 1'b1;
        end else if (wb_adr_o !== cur.adr || wb_dat_o !== cur.dat ||
                     wb_we_o !== cur.we || wb_sel_o !== cur.sel) begin
          cur.stable = 1'b0;
        end
        if (wb_stb_o !== 1'b1) cur.stable = 1'b0;
        wb_ack_i = (cur.ncyc == cur_delay);
        wb_dat_i = wb_ack_i ? cur_rdata : $urandom();
        cur.ncyc++;
      end else begin
        if (in_cyc) begin
          in_cyc = 1'b0;
          mon_q.push_back(cur);
        end
        // Stray acks outside a cycle must be ignored.
        wb_ack_i = ($urandom_range(0, 3) == 0);
        wb_dat_i = $urandom();
      end
    end
  end

  // UART tx sink: random or directed ready, checks data holds while stalled.
  int         tx_q[$];
  int         txc_q[$];
  int         first_valid = -1;
  int         rdy_mode    = 0;
  bit         pend        = 1'b0;
  logic [7:0] pend_data   = '0;
  int         wait_left   = 0;

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) check("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, pend_data});
      if (tx_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc_n;
        if (!pend) begin
          pend_data = tx_data;
          if (rdy_mode == 1) wait_left = (tx_q.size() == 1) ? 5 : 0;
          else               wait_left = $urandom_range(0, 2);
        end
        if (wait_left == 0) begin
          tx_ready = 1'b1;
          tx_q.push_back(int'(tx_data));
          txc_q.push_back(cyc_n);
          pend = 1'b0;
        end else begin
          tx_ready = 1'b0;
          wait_left--;
          pend = 1'b1;
        end
      end else begin
        pend     = 1'b0;
        tx_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1);
  end

  bit exp_ovr = 1'b0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom());
  endtask

  task automatic send_junk();
    logic [7:0] b;
    do b = 8'($urandom()); while (b == CMD_WR || b == CMD_RD);
    send_byte(b);
  endtask

  // One frame end to end: expected bus cycle and response derived from the frame rules.
  task automatic do_cmd(input bit wr, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] rdata, input int delay, input bit inject,
                        input int mode);
    logic [7:0] bytes[$];
    int         exp_tx[$];
    int         last_rx;
    int         waited;
    bus_rec_t   r;
    bit         ok;
    int         exp_ncyc;

    cur_delay   = delay;
    cur_rdata   = rdata;
    rdy_mode    = mode;
    tx_q.delete();
    txc_q.delete();
    first_valid = -1;

    ok       = (delay < int'(TMO));
    exp_ncyc = ok ? delay + 1 : int'(TMO);
    if (!ok)     exp_tx.push_back(int'(RSP_ERR));
    else if (wr) exp_tx.push_back(int'(RSP_OK));
    else for (int i = 3; i >= 0; i--) exp_tx.push_back(int'(rdata[i*8 +: 8]));

    bytes.push_back(wr ? CMD_WR : CMD_RD);
    for (int i = 3; i >= 0; i--) bytes.push_back(adr[i*8 +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) bytes.push_back(dat[i*8 +: 8]);
    foreach (bytes[i]) begin
      step($urandom_range(0, 2));
      send_byte(bytes[i]);
    end
    last_rx = cyc_n;
    if (inject) begin
      send_byte(8'($urandom()));
      exp_ovr = 1'b1;
    end

    waited = 0;
    while (tx_q.size() < exp_tx.size() && waited < 400) begin
      step(1);
      waited++;
    end
    step(4);
    check("tx_count", 64'(tx_q.size()), 64'(exp_tx.size()));
    foreach (exp_tx[i])
      if (i < tx_q.size()) check($sformatf("tx_byte%0d", i), 64'(tx_q[i]), 64'(exp_tx[i]));
    for (int i = 1; i < txc_q.size(); i++)
      check("tx_gap", 64'(txc_q[i] - txc_q[i-1] >= 2), 64'd1);

    check("bus_count", 64'(mon_q.size()), 64'd1);
    if (mon_q.size() > 0) begin
      r = mon_q.pop_front();
      check("bus_adr", 64'(r.adr), 64'(adr));
      check("bus_we", 64'(r.we), 64'(wr));
      check("bus_sel", 64'(r.sel), 64'hF);
      if (wr) check("bus_dat", 64'(r.dat), 64'(dat));
      check("bus_stable", 64'(r.stable), 64'd1);
      check("bus_len", 64'(r.ncyc), 64'(exp_ncyc));
      check("lat_cmd", 64'(r.start), 64'(last_rx));
      check("lat_rsp", 64'(first_valid), 64'(r.start + r.ncyc));
    end
    mon_q.delete();
    check("overrun", 64'(overrun), 64'(exp_ovr));
  endtask

  task automatic reset_mid_bus();
    cur_delay = 1000;
    tx_q.delete();
    send_byte(CMD_RD);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom()));
    send_byte(8'h33);
    step(2);
    check("mid_ovr", 64'(overrun), 64'd1);
    check("mid_cyc", 64'(wb_cyc_o), 64'd1);
    rst = 1'b0;
    step(1);
    check("rst_mid_out", {53'd0, wb_cyc_o, wb_stb_o, tx_valid, overrun, wb_we_o, wb_sel_o, 2'b00}, 64'd0);
    check("rst_mid_adr", 64'(wb_adr_o), 64'd0);
    rst     = 1'b1;
    exp_ovr = 1'b0;
    step(30);
    check("rst_no_rsp", 64'(tx_q.size()), 64'd0);
    check("rst_bus_seen", 64'(mon_q.size()), 64'd1);
    mon_q.delete();
  endtask

  initial begin
    int d;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    step(3);
    check("rst_out", {48'd0, tx_valid, tx_data, overrun, wb_sel_o, wb_we_o, wb_cyc_o}, 64'd0);
    check("rst_adr", 64'(wb_adr_o), 64'd0);
    check("rst_dat", 64'(wb_dat_o), 64'd0);
    rst = 1'b1;
    step(2);

    do_cmd(1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, 0);
    do_cmd(1'b0, 32'h5000_0008, 32'h0, 32'h1234_5678, 1, 1'b0, 1);
    do_cmd(1'b0, 32'h5000_000C, 32'h0, 32'hCAFE_F00D, 100, 1'b0, 0);
    do_cmd(1'b1, 32'h1000_0000, 32'h0000_00A5, 32'h0, 0, 1'b0, 0);

    send_byte(8'h00);
    step(1);
    send_byte(8'hFF);
    do_cmd(1'b1, 32'h2000_0010, 32'h0102_0304, 32'h0, 3, 1'b1, 0);
    do_cmd(1'b1, 32'h2000_0014, 32'hA5A5_5A5A, 32'h0, int'(TMO) - 1, 1'b0, 0);
    do_cmd(1'b0, 32'h2000_0018, 32'h0, 32'h8765_4321, int'(TMO) - 1, 1'b0, 0);
    do_cmd(1'b1, 32'h2000_001C, 32'h1111_2222, 32'h0, int'(TMO), 1'b0, 0);

    reset_mid_bus();
    do_cmd(1'b0, 32'h3000_0000, 32'h0, 32'hFEDC_BA98, 4, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0:       d = 0;
        1:       d = 1;
        2:       d = $urandom_range(2, 8);
        3:       d = int'(TMO) - 1;
        4:       d = int'(TMO);
        default: d = int'(TMO) + 5;
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) send_junk();
      do_cmd(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), d,
             ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
